// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) slave to register-file bridge: 32-bit frames {cmd, addr, data16}.
// Optional aborted-frame counter compiled in with `define SPI_REG_BRIDGE_ERR_CNT_EN.
module spi_reg_bridge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        write_en,
    output logic        read_en,
    output logic [7:0]  address,
    output logic [15:0] wr_data,
    input  logic [15:0] rd_data,
    output logic [7:0]  err_count
);

    localparam int unsigned CNT_W    = 6;
    localparam int unsigned SETTLE_W = 2;
    localparam logic [CNT_W-1:0] HDR_BITS   = CNT_W'(16);
    localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(32);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic [SETTLE_W-1:0]    r_settle;
    logic                   r_armed;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [31:0]      r_rx_sr;
    logic [15:0]      r_tx_sr;
    logic             r_is_read;
    logic             r_miso;
    logic             r_write_en;
    logic             r_read_en;
    logic [7:0]       r_address;
    logic [15:0]      r_wr_data;

    logic       w_sclk_s;
    logic       w_cs_s;
    logic       w_mosi_s;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_sample;
    logic [2:0] w_state_next;
    logic       w_abort;
    logic       w_rd_req;
    logic       w_wr_req;
    logic       w_capture;
    logic       w_miso_next;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_sample    = w_sclk_rise & ~w_cs_s &
                         ((r_state == S_HDR) || (r_state == S_RD_REQ) ||
                          (r_state == S_RD_WAIT) || (r_state == S_DATA));

    // Input synchronizers and edge-detect history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    // A frame already in flight at reset release must not look like a new cs_n fall:
    // only arm once the synchronizer holds real samples showing cs_n high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != SETTLE_W'(SYNC_STAGES)) begin
                r_settle <= r_settle + SETTLE_W'(1);
            end
            if ((r_settle == SETTLE_W'(SYNC_STAGES)) && w_cs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        w_rd_req     = 1'b0;
        w_wr_req     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_bit_cnt == HDR_BITS) begin
                    w_rd_req     = r_rx_sr[15];
                    w_state_next = r_rx_sr[15] ? S_RD_REQ : S_DATA;
                end
            end
            S_RD_REQ: begin
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_capture    = 1'b1;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_bit_cnt == FRAME_BITS) begin
                    w_wr_req     = ~r_is_read;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_cs_rise) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // miso is forced low outside read DATA and only moves on sclk falling edges
    always_comb begin
        w_miso_next = 1'b0;
        if ((w_state_next == S_DATA) && r_is_read) begin
            w_miso_next = r_miso;
            if ((r_state == S_DATA) && w_sclk_fall) begin
                w_miso_next = r_tx_sr[15];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            r_is_read  <= 1'b0;
            r_miso     <= 1'b0;
            r_write_en <= 1'b0;
            r_read_en  <= 1'b0;
            r_address  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_miso     <= w_miso_next;
            r_write_en <= w_wr_req;
            r_read_en  <= w_rd_req;

            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_sample && (r_bit_cnt != FRAME_BITS)) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            if (w_sample) begin
                r_rx_sr <= {r_rx_sr[30:0], w_mosi_s};
            end

            if (r_state == S_IDLE) begin
                r_is_read <= 1'b0;
            end else if ((r_state == S_HDR) && (r_bit_cnt == HDR_BITS)) begin
                r_is_read <= r_rx_sr[15];
            end

            if (w_capture) begin
                r_tx_sr <= rd_data;
            end else if ((r_state == S_DATA) && r_is_read && w_sclk_fall) begin
                r_tx_sr <= {r_tx_sr[14:0], 1'b0};
            end

            if (w_rd_req) begin
                r_address <= r_rx_sr[7:0];
            end else if (w_wr_req) begin
                r_address <= r_rx_sr[23:16];
            end

            if (w_wr_req) begin
                r_wr_data <= r_rx_sr[15:0];
            end
        end
    end

    assign miso     = r_miso;
    assign write_en = r_write_en;
    assign read_en  = r_read_en;
    assign address  = r_address;
    assign wr_data  = r_wr_data;

`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of frames cut short by cs_n
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_abort && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 8'd0;
`endif

endmodule
